rv_pipe_ctrl: RTL and testbench
===============================

// Module: rv_pipe_ctrl
// PURPOSE
//  Parametrised pipeline control unit for the 5-stage RV32I core; next generation of rv_hazard_unit.
//  Adds per-stage stall/bubble control, multi-cycle memory handshakes (imem/dmem ack), a configurable load-use bubble count,
//  a dmem watchdog with sticky error, and a saturating stall-cycle counter. Drives forwarding selects to ID and EX.
// PARAMETERS
//  LU_CYC   1   load-use bubbles inserted into ID/EX (1..7).
//  TIMEOUT  15  max cycles in MEM_WAIT before error (1..255).
//  CNT_W    16  stall-cycle counter width.
// PORTS
//  i_pc_clk          in   1      core clock
//  i_pc_rstn         in   1      reset; one clock, synchronous, active-low
//  i_pc_ra1_id/ra2_id in  5 each ID source regs
//  i_pc_ra1_ex/ra2_ex in  5 each EX source regs
//  i_pc_we_ex, i_pc_is_load_ex, i_pc_wa_ex  in 1,1,5  EX dest info
//  i_pc_we_mem, i_pc_is_load_mem, i_pc_wa_mem in 1,1,5 MEM dest info
//  i_pc_we_wb, i_pc_wa_wb  in 1,5  WB dest info
//  i_pc_flush_ex     in   1      EX resolved taken branch/jump
//  i_pc_imem_ack     in   1      imem data valid this cycle
//  i_pc_dmem_req     in   1      MEM stage holds load/store
//  i_pc_dmem_ack     in   1      dmem access complete this cycle
//  o_pc_rd1_sel_ex/rd2_sel_ex out 2 each  00 regfile, 01 MEM fwd, 10 WB fwd
//  o_pc_rd1_sel_id/rd2_sel_id out 1 each  1 = WB bypass into ID
//  o_pc_stall_if/id/ex/mem out 1 each  hold that stage's pipeline register
//  o_pc_bubble_ex    out  1      load NOP into ID/EX
//  o_pc_bubble_wb    out  1      load NOP into MEM/WB
//  o_pc_flush_ifid   out  1      squash IF/ID and ID/EX
//  o_pc_dmem_err     out  1      sticky dmem timeout
//  o_pc_stall_cnt    out  CNT_W  cycles with o_pc_stall_if=1
// BEHAVIOUR
//  Reset (i_pc_rstn=0 at edge): state RUN, lu/wd counters 0, err 0, stall_cnt 0. All outputs 0 while rstn=0 (forced).
//  Forwarding (comb): EX sel=01 if we_mem & wa_mem!=0 & wa_mem==ra_ex & !is_load_mem;
//   else 10 if we_wb & wa_wb!=0 & wa_wb==ra_ex; else 00. MEM wins over WB. ID sel=1 if we_wb & wa_wb!=0 & wa_wb==ra_id.
//  Load-use hit: is_load_ex & we_ex & wa_ex!=0 & (wa_ex==ra1_id | wa_ex==ra2_id).
//  FSM states RUN, LU_STALL, MEM_WAIT, ERR. Priority: MEM_WAIT > load-use > imem wait.
//   RUN: dmem_req & !dmem_ack -> MEM_WAIT (wd=1). Else load-use hit -> LU_STALL (lu=1) if LU_CYC>1, stays RUN if LU_CYC=1.
//   LU_STALL: lu increments; lu==LU_CYC-1 -> RUN; dmem_req & !dmem_ack preempts -> MEM_WAIT, lu cleared (re-detected).
//   MEM_WAIT: dmem_ack -> RUN; wd increments; wd==TIMEOUT & !ack -> ERR. ERR: held until reset.
//  Stall outputs (comb from state+inputs):
//   dmem wait (RUN with req&!ack, MEM_WAIT): stall_if/id/ex/mem=1, bubble_wb=1, bubble_ex=0.
//   load-use (hit in RUN, or LU_STALL): stall_if/id=1, bubble_ex=1, stall_ex/mem=0.
//   imem wait (!imem_ack, none above): stall_if/id=1, bubble_ex=1.
//   ERR: stall_if/id/ex/mem=1, bubble_ex=bubble_wb=1, dmem_err=1.
//  Flush: o_pc_flush_ifid = flush_ex & !stall_ex; deferred while EX frozen; overrides load-use/imem stall (stall_if/id, bubble_ex
//   forced 0 in that cycle, LU_STALL -> RUN).
//  Dmem req with same-cycle ack: zero stall cycles. Back-to-back accesses re-enter MEM_WAIT each time.
//  Stall counter: +1 per cycle with stall_if=1; saturates at 2^CNT_W-1; no wrap.
//  Reset mid-MEM_WAIT or mid-LU_STALL: next cycle RUN, counters 0, no residual stall.
// TESTING
//  add x1 in MEM, EX reads x1, WB writes x1 -> rd1_sel_ex=01 (MEM priority); wa=0 in all stages -> 00.
//  lw x5 in EX, ID reads x5, LU_CYC=1 -> 1 cycle stall_if/id=1, bubble_ex=1; LU_CYC=3 -> exactly 3 cycles.
//  dmem_req=1, ack after 4 cycles -> stall_if/id/ex/mem=1 and bubble_wb=1 for 4 cycles, 0 on ack cycle.
//  dmem_req=1, ack never, TIMEOUT=15 -> ERR after 15 wait cycles, dmem_err=1 until rstn=0 one cycle.
//  flush_ex=1 during MEM_WAIT -> flush_ifid=0 until ack cycle, then 1 for one cycle.
//  CNT_W=4, continuous imem_ack=0 for 20 cycles -> stall_cnt stops at 15.

Source files
------------

// File: rtl/rv_pipe_ctrl.sv
// rv_pipe_ctrl: pipeline control for the 5-stage RV32I core.
// Computes forwarding selects for ID and EX, per-stage stall/bubble/flush
// controls, tracks multi-cycle dmem accesses with a watchdog that latches a
// sticky error, and counts front-end stall cycles with a saturating counter.
module rv_pipe_ctrl #(
  parameter int unsigned LU_CYC  = 1,
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             i_pc_clk,
  input  logic             i_pc_rstn,
  input  logic [4:0]       i_pc_ra1_id,
  input  logic [4:0]       i_pc_ra2_id,
  input  logic [4:0]       i_pc_ra1_ex,
  input  logic [4:0]       i_pc_ra2_ex,
  input  logic             i_pc_we_ex,
  input  logic             i_pc_is_load_ex,
  input  logic [4:0]       i_pc_wa_ex,
  input  logic             i_pc_we_mem,
  input  logic             i_pc_is_load_mem,
  input  logic [4:0]       i_pc_wa_mem,
  input  logic             i_pc_we_wb,
  input  logic [4:0]       i_pc_wa_wb,
  input  logic             i_pc_flush_ex,
  input  logic             i_pc_imem_ack,
  input  logic             i_pc_dmem_req,
  input  logic             i_pc_dmem_ack,
  output logic [1:0]       o_pc_rd1_sel_ex,
  output logic [1:0]       o_pc_rd2_sel_ex,
  output logic             o_pc_rd1_sel_id,
  output logic             o_pc_rd2_sel_id,
  output logic             o_pc_stall_if,
  output logic             o_pc_stall_id,
  output logic             o_pc_stall_ex,
  output logic             o_pc_stall_mem,
  output logic             o_pc_bubble_ex,
  output logic             o_pc_bubble_wb,
  output logic             o_pc_flush_ifid,
  output logic             o_pc_dmem_err,
  output logic [CNT_W-1:0] o_pc_stall_cnt
);

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_LU_STALL = 2'd1;
  localparam logic [1:0] ST_MEM_WAIT = 2'd2;
  localparam logic [1:0] ST_ERR      = 2'd3;

  localparam logic [2:0] LU_LAST  = 3'(LU_CYC - 1);
  localparam logic [7:0] WD_LIMIT = 8'(TIMEOUT);
  localparam bit         LU_MULTI = (LU_CYC > 1);

  logic [1:0]       state_q, state_d;
  logic [2:0]       lu_q, lu_d;
  logic [7:0]       wd_q, wd_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic [1:0] rd1_sel_ex, rd2_sel_ex;
  logic       rd1_sel_id, rd2_sel_id;
  logic       mem_fwd_ok, wb_fwd_ok;
  logic       lu_hit, dmem_pend, in_err, dmem_wait, lu_wait, if_wait;
  logic       front_stall, stall_if, stall_ex, flush_ifid, bubble_ex;

  // Forwarding selects: MEM result beats WB result; loads in MEM cannot forward yet.
  always_comb begin
    mem_fwd_ok = i_pc_we_mem && (i_pc_wa_mem != 5'd0) && !i_pc_is_load_mem;
    wb_fwd_ok  = i_pc_we_wb && (i_pc_wa_wb != 5'd0);
    rd1_sel_ex = 2'b00;
    rd2_sel_ex = 2'b00;
    if (mem_fwd_ok && (i_pc_wa_mem == i_pc_ra1_ex))     rd1_sel_ex = 2'b01;
    else if (wb_fwd_ok && (i_pc_wa_wb == i_pc_ra1_ex))  rd1_sel_ex = 2'b10;
    if (mem_fwd_ok && (i_pc_wa_mem == i_pc_ra2_ex))     rd2_sel_ex = 2'b01;
    else if (wb_fwd_ok && (i_pc_wa_wb == i_pc_ra2_ex))  rd2_sel_ex = 2'b10;
    rd1_sel_id = wb_fwd_ok && (i_pc_wa_wb == i_pc_ra1_id);
    rd2_sel_id = wb_fwd_ok && (i_pc_wa_wb == i_pc_ra2_id);
  end

  // Stall/bubble/flush decode: dmem wait outranks load-use, which outranks imem wait.
  always_comb begin
    lu_hit      = i_pc_is_load_ex && i_pc_we_ex && (i_pc_wa_ex != 5'd0) &&
                  ((i_pc_wa_ex == i_pc_ra1_id) || (i_pc_wa_ex == i_pc_ra2_id));
    dmem_pend   = i_pc_dmem_req && !i_pc_dmem_ack;
    in_err      = (state_q == ST_ERR);
    dmem_wait   = 1'b0;
    if (state_q == ST_MEM_WAIT)   dmem_wait = !i_pc_dmem_ack;
    else if (!in_err)             dmem_wait = dmem_pend;
    lu_wait     = !in_err && !dmem_wait && (lu_hit || (state_q == ST_LU_STALL));
    if_wait     = !in_err && !dmem_wait && !lu_wait && !i_pc_imem_ack;
    stall_ex    = in_err || dmem_wait;
    flush_ifid  = i_pc_flush_ex && !stall_ex;
    front_stall = (lu_wait || if_wait) && !flush_ifid;
    stall_if    = stall_ex || front_stall;
    bubble_ex   = in_err || front_stall;
  end

  // Next-state logic for the hazard FSM plus load-use and watchdog counters.
  always_comb begin
    state_d = state_q;
    lu_d    = lu_q;
    wd_d    = wd_q;
    case (state_q)
      ST_RUN: begin
        if (dmem_pend) begin
          state_d = ST_MEM_WAIT;
          wd_d    = 8'd1;
        end else if (LU_MULTI && lu_hit && !flush_ifid) begin
          state_d = ST_LU_STALL;
          lu_d    = 3'd1;
        end
      end
      ST_LU_STALL: begin
        if (dmem_pend) begin
          state_d = ST_MEM_WAIT;
          wd_d    = 8'd1;
          lu_d    = 3'd0;
        end else if (flush_ifid || (lu_q == LU_LAST)) begin
          state_d = ST_RUN;
          lu_d    = 3'd0;
        end else begin
          lu_d = lu_q + 3'd1;
        end
      end
      ST_MEM_WAIT: begin
        if (i_pc_dmem_ack) begin
          wd_d = 8'd0;
          if (LU_MULTI && lu_hit && !flush_ifid) begin
            state_d = ST_LU_STALL;
            lu_d    = 3'd1;
          end else begin
            state_d = ST_RUN;
          end
        end else if (wd_q == WD_LIMIT) begin
          state_d = ST_ERR;
        end else begin
          wd_d = wd_q + 8'd1;
        end
      end
      default: state_d = ST_ERR;
    endcase
  end

  // Saturating count of cycles in which the fetch stage is held.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_if && (stall_cnt_q != {CNT_W{1'b1}})) stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge i_pc_clk) begin
    if (!i_pc_rstn) begin
      state_q     <= ST_RUN;
      lu_q        <= 3'd0;
      wd_q        <= 8'd0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      lu_q        <= lu_d;
      wd_q        <= wd_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign o_pc_rd1_sel_ex = i_pc_rstn ? rd1_sel_ex : 2'b00;
  assign o_pc_rd2_sel_ex = i_pc_rstn ? rd2_sel_ex : 2'b00;
  assign o_pc_rd1_sel_id = i_pc_rstn && rd1_sel_id;
  assign o_pc_rd2_sel_id = i_pc_rstn && rd2_sel_id;
  assign o_pc_stall_if   = i_pc_rstn && stall_if;
  assign o_pc_stall_id   = i_pc_rstn && stall_if;
  assign o_pc_stall_ex   = i_pc_rstn && stall_ex;
  assign o_pc_stall_mem  = i_pc_rstn && stall_ex;
  assign o_pc_bubble_ex  = i_pc_rstn && bubble_ex;
  assign o_pc_bubble_wb  = i_pc_rstn && stall_ex;
  assign o_pc_flush_ifid = i_pc_rstn && flush_ifid;
  assign o_pc_dmem_err   = i_pc_rstn && in_err;
  assign o_pc_stall_cnt  = i_pc_rstn ? stall_cnt_q : '0;

endmodule

// File: tb/tb_rv_pipe_ctrl.sv
// tb_rv_pipe_ctrl: scoreboard bench for rv_pipe_ctrl.
// Two instances share the stimulus: dut_a (LU_CYC=1, CNT_W=4) and
// dut_b (LU_CYC=3, CNT_W=16), both with TIMEOUT=15.
module tb_rv_pipe_ctrl;

  typedef struct packed {
    logic       rstn;
    logic [4:0] ra1_id, ra2_id, ra1_ex, ra2_ex;
    logic       we_ex, is_load_ex;
    logic [4:0] wa_ex;
    logic       we_mem, is_load_mem;
    logic [4:0] wa_mem;
    logic       we_wb;
    logic [4:0] wa_wb;
    logic       flush_ex, imem_ack, dmem_req, dmem_ack;
  } stim_t;

  typedef struct {
    string       name;
    logic [13:0] exp_a;
    logic [13:0] exp_b;
    int          cnt_a;
    int          cnt_b;
  } exp_t;

  // {rd1_sel_ex, rd2_sel_ex, rd1_sel_id, rd2_sel_id, stall_if, stall_id,
  //  stall_ex, stall_mem, bubble_ex, bubble_wb, flush_ifid, dmem_err}
  localparam logic [13:0] P_NONE = 14'h0000;
  localparam logic [13:0] P_LU   = 14'h00C8;
  localparam logic [13:0] P_DW   = 14'h00F4;
  localparam logic [13:0] P_ERR  = 14'h00FD;
  localparam logic [13:0] P_FL   = 14'h0002;

  logic  clk;
  stim_t cur;
  stim_t s;
  stim_t idle;
  exp_t  sbq[$];
  exp_t  mon_e;
  int    total;
  int    bad;

  logic [1:0]  a_rd1_ex, a_rd2_ex, b_rd1_ex, b_rd2_ex;
  logic        a_rd1_id, a_rd2_id, b_rd1_id, b_rd2_id;
  logic        a_sif, a_sid, a_sex, a_smem, a_bex, a_bwb, a_fl, a_err;
  logic        b_sif, b_sid, b_sex, b_smem, b_bex, b_bwb, b_fl, b_err;
  logic [3:0]  a_cnt;
  logic [15:0] b_cnt;
  logic [13:0] act_a, act_b;

  assign act_a = {a_rd1_ex, a_rd2_ex, a_rd1_id, a_rd2_id, a_sif, a_sid, a_sex, a_smem, a_bex, a_bwb, a_fl, a_err};
  assign act_b = {b_rd1_ex, b_rd2_ex, b_rd1_id, b_rd2_id, b_sif, b_sid, b_sex, b_smem, b_bex, b_bwb, b_fl, b_err};

  rv_pipe_ctrl #(.LU_CYC(1), .TIMEOUT(15), .CNT_W(4)) dut_a (
    .i_pc_clk(clk), .i_pc_rstn(cur.rstn),
    .i_pc_ra1_id(cur.ra1_id), .i_pc_ra2_id(cur.ra2_id),
    .i_pc_ra1_ex(cur.ra1_ex), .i_pc_ra2_ex(cur.ra2_ex),
    .i_pc_we_ex(cur.we_ex), .i_pc_is_load_ex(cur.is_load_ex), .i_pc_wa_ex(cur.wa_ex),
    .i_pc_we_mem(cur.we_mem), .i_pc_is_load_mem(cur.is_load_mem), .i_pc_wa_mem(cur.wa_mem),
    .i_pc_we_wb(cur.we_wb), .i_pc_wa_wb(cur.wa_wb),
    .i_pc_flush_ex(cur.flush_ex), .i_pc_imem_ack(cur.imem_ack),
    .i_pc_dmem_req(cur.dmem_req), .i_pc_dmem_ack(cur.dmem_ack),
    .o_pc_rd1_sel_ex(a_rd1_ex), .o_pc_rd2_sel_ex(a_rd2_ex),
    .o_pc_rd1_sel_id(a_rd1_id), .o_pc_rd2_sel_id(a_rd2_id),
    .o_pc_stall_if(a_sif), .o_pc_stall_id(a_sid), .o_pc_stall_ex(a_sex), .o_pc_stall_mem(a_smem),
    .o_pc_bubble_ex(a_bex), .o_pc_bubble_wb(a_bwb), .o_pc_flush_ifid(a_fl),
    .o_pc_dmem_err(a_err), .o_pc_stall_cnt(a_cnt)
  );

  rv_pipe_ctrl #(.LU_CYC(3), .TIMEOUT(15), .CNT_W(16)) dut_b (
    .i_pc_clk(clk), .i_pc_rstn(cur.rstn),
    .i_pc_ra1_id(cur.ra1_id), .i_pc_ra2_id(cur.ra2_id),
    .i_pc_ra1_ex(cur.ra1_ex), .i_pc_ra2_ex(cur.ra2_ex),
    .i_pc_we_ex(cur.we_ex), .i_pc_is_load_ex(cur.is_load_ex), .i_pc_wa_ex(cur.wa_ex),
    .i_pc_we_mem(cur.we_mem), .i_pc_is_load_mem(cur.is_load_mem), .i_pc_wa_mem(cur.wa_mem),
    .i_pc_we_wb(cur.we_wb), .i_pc_wa_wb(cur.wa_wb),
    .i_pc_flush_ex(cur.flush_ex), .i_pc_imem_ack(cur.imem_ack),
    .i_pc_dmem_req(cur.dmem_req), .i_pc_dmem_ack(cur.dmem_ack),
    .o_pc_rd1_sel_ex(b_rd1_ex), .o_pc_rd2_sel_ex(b_rd2_ex),
    .o_pc_rd1_sel_id(b_rd1_id), .o_pc_rd2_sel_id(b_rd2_id),
    .o_pc_stall_if(b_sif), .o_pc_stall_id(b_sid), .o_pc_stall_ex(b_sex), .o_pc_stall_mem(b_smem),
    .o_pc_bubble_ex(b_bex), .o_pc_bubble_wb(b_bwb), .o_pc_flush_ifid(b_fl),
    .o_pc_dmem_err(b_err), .o_pc_stall_cnt(b_cnt)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one cycle of inputs just after the rising edge and queue its expectation.
  task automatic applyStimulus(input stim_t st, input string nm, input logic [13:0] ea,
                               input logic [13:0] eb, input int ca, input int cb);
    exp_t e;
    @(posedge clk);
    #1;
    cur = st;
    e.name  = nm;
    e.exp_a = ea;
    e.exp_b = eb;
    e.cnt_a = ca;
    e.cnt_b = cb;
    sbq.push_back(e);
  endtask

  // Compare both instances' outputs and stall counters against one expectation.
  task automatic checkOutput(input exp_t e);
    total++;
    if (act_a !== e.exp_a) begin
      bad++;
      $display("[TB] FAIL %s dut_a ctrl: got %h want %h", e.name, act_a, e.exp_a);
    end
    total++;
    if (act_b !== e.exp_b) begin
      bad++;
      $display("[TB] FAIL %s dut_b ctrl: got %h want %h", e.name, act_b, e.exp_b);
    end
    total++;
    if (int'(a_cnt) != e.cnt_a || $isunknown(a_cnt)) begin
      bad++;
      $display("[TB] FAIL %s dut_a stall_cnt: got %0d want %0d", e.name, a_cnt, e.cnt_a);
    end
    total++;
    if (int'(b_cnt) != e.cnt_b || $isunknown(b_cnt)) begin
      bad++;
      $display("[TB] FAIL %s dut_b stall_cnt: got %0d want %0d", e.name, b_cnt, e.cnt_b);
    end
  endtask

  task automatic doReset();
    stim_t r;
    r = idle;
    r.rstn = 1'b0;
    applyStimulus(r, "reset", P_NONE, P_NONE, 0, 0);
  endtask

  // Monitor: at mid-cycle, pop the oldest expectation and compare.
  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      mon_e = sbq.pop_front();
      checkOutput(mon_e);
    end
  end

  // Directed scenarios.
  initial begin
    total = 0;
    bad   = 0;
    idle  = '0;
    idle.rstn     = 1'b1;
    idle.imem_ack = 1'b1;
    cur = idle;
    cur.rstn = 1'b0;

    doReset();
    doReset();

    // Forwarding
    s = idle; s.we_mem = 1; s.wa_mem = 5'd1; s.we_wb = 1; s.wa_wb = 5'd1;
    s.ra1_ex = 5'd1; s.ra2_ex = 5'd2; s.ra1_id = 5'd1;
    applyStimulus(s, "fwd_mem_priority", 14'h1200, 14'h1200, 0, 0);
    s = idle; s.we_mem = 1; s.we_wb = 1; s.we_ex = 1;
    applyStimulus(s, "fwd_x0", P_NONE, P_NONE, 0, 0);
    s = idle; s.we_mem = 1; s.is_load_mem = 1; s.wa_mem = 5'd3; s.we_wb = 1; s.wa_wb = 5'd3;
    s.ra2_ex = 5'd3;
    applyStimulus(s, "fwd_load_in_mem", 14'h0800, 14'h0800, 0, 0);
    s = idle; s.we_wb = 1; s.wa_wb = 5'd7; s.ra1_ex = 5'd7; s.ra2_ex = 5'd7; s.ra2_id = 5'd7;
    applyStimulus(s, "fwd_wb_both", 14'h2900, 14'h2900, 0, 0);

    // Load-use: one bubble for dut_a, three for dut_b
    doReset();
    s = idle; s.is_load_ex = 1; s.we_ex = 1; s.wa_ex = 5'd5; s.ra2_id = 5'd5;
    applyStimulus(s, "lu_hit", P_LU, P_LU, 0, 0);
    applyStimulus(idle, "lu_c1", P_NONE, P_LU, 1, 1);
    applyStimulus(idle, "lu_c2", P_NONE, P_LU, 1, 2);
    applyStimulus(idle, "lu_done", P_NONE, P_NONE, 1, 3);
    s = idle; s.is_load_ex = 1; s.we_ex = 1;
    applyStimulus(s, "lu_x0", P_NONE, P_NONE, 1, 3);

    // Flush overrides load-use and imem stalls
    doReset();
    s = idle; s.is_load_ex = 1; s.we_ex = 1; s.wa_ex = 5'd5; s.ra1_id = 5'd5;
    applyStimulus(s, "fl_lu_hit", P_LU, P_LU, 0, 0);
    s = idle; s.flush_ex = 1;
    applyStimulus(s, "fl_lu_stall", P_FL, P_FL, 1, 1);
    s = idle; s.flush_ex = 1; s.imem_ack = 0;
    applyStimulus(s, "fl_imem", P_FL, P_FL, 1, 1);
    s = idle; s.imem_ack = 0;
    applyStimulus(s, "imem_one", P_LU, P_LU, 1, 1);
    applyStimulus(idle, "fl_after", P_NONE, P_NONE, 2, 2);

    // Dmem wait preempts an active load-use stall
    doReset();
    s = idle; s.is_load_ex = 1; s.we_ex = 1; s.wa_ex = 5'd9; s.ra2_id = 5'd9;
    applyStimulus(s, "pre_lu_hit", P_LU, P_LU, 0, 0);
    s = idle; s.dmem_req = 1;
    applyStimulus(s, "pre_dmem", P_DW, P_DW, 1, 1);
    s.dmem_ack = 1;
    applyStimulus(s, "pre_ack", P_NONE, P_NONE, 2, 2);
    applyStimulus(idle, "pre_after", P_NONE, P_NONE, 2, 2);

    // Dmem ack after 4 cycles with a deferred flush, then back-to-back and same-cycle ack
    doReset();
    s = idle; s.dmem_req = 1; s.flush_ex = 1;
    for (int k = 0; k < 4; k++) applyStimulus(s, "dw_wait", P_DW, P_DW, k, k);
    s.dmem_ack = 1;
    applyStimulus(s, "dw_ack_flush", P_FL, P_FL, 4, 4);
    s = idle; s.dmem_req = 1;
    applyStimulus(s, "dw_b2b_wait", P_DW, P_DW, 4, 4);
    s.dmem_ack = 1;
    applyStimulus(s, "dw_b2b_ack", P_NONE, P_NONE, 5, 5);
    applyStimulus(s, "dw_same_cycle", P_NONE, P_NONE, 5, 5);
    applyStimulus(idle, "dw_idle", P_NONE, P_NONE, 5, 5);

    // Watchdog timeout into sticky error
    doReset();
    s = idle; s.dmem_req = 1;
    for (int k = 0; k < 16; k++) applyStimulus(s, "to_wait", P_DW, P_DW, k, k);
    s.flush_ex = 1;
    applyStimulus(s, "to_err", P_ERR, P_ERR, 15, 16);
    s = idle; s.dmem_ack = 1;
    applyStimulus(s, "to_err_sticky", P_ERR, P_ERR, 15, 17);
    doReset();
    applyStimulus(idle, "to_cleared", P_NONE, P_NONE, 0, 0);

    // Reset in the middle of MEM_WAIT and of LU_STALL
    s = idle; s.dmem_req = 1;
    applyStimulus(s, "rst_mw0", P_DW, P_DW, 0, 0);
    applyStimulus(s, "rst_mw1", P_DW, P_DW, 1, 1);
    doReset();
    applyStimulus(idle, "rst_mw_after", P_NONE, P_NONE, 0, 0);
    s = idle; s.is_load_ex = 1; s.we_ex = 1; s.wa_ex = 5'd4; s.ra1_id = 5'd4;
    applyStimulus(s, "rst_lu0", P_LU, P_LU, 0, 0);
    doReset();
    applyStimulus(idle, "rst_lu_after", P_NONE, P_NONE, 0, 0);

    // Continuous imem wait: 4-bit counter saturates at 15
    s = idle; s.imem_ack = 0;
    for (int k = 0; k < 20; k++) applyStimulus(s, "imem_wait", P_LU, P_LU, (k > 15) ? 15 : k, k);
    applyStimulus(idle, "imem_sat", P_NONE, P_NONE, 15, 20);

    for (int i = 0; i < 5 && sbq.size() > 0; i++) @(posedge clk);
    if (sbq.size() > 0) begin
      total++;
      bad++;
      $display("[TB] FAIL drain: got %0d pending want 0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
